// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide op encodings, HI/LO unit FSM states
// and the per-operation context latched when an operation is accepted.
package mips_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FINISH = 2'b10
   } md_state_e;

   typedef struct packed {
      logic is_div;
      logic neg_res;   // negate product / quotient
      logic neg_rem;   // negate remainder (dividend was negative)
      logic b_zero;
   } md_ctx_t;

   function automatic logic op_is_div(input logic [OP_W-1:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [OP_W-1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider: add-shift-right for multiply,
// restoring subtract-shift-left for divide. Operates on unsigned magnitudes.
module muldiv_step
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] acc_c,
   output logic [WIDTH-1:0] q_c
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // Divide relies on acc < divisor, so a set sh[WIDTH] guarantees the subtract succeeds
   // and the 32-bit difference is exact.
   always_comb begin
      sum   = '0;
      sh    = '0;
      diff  = '0;
      ge    = 1'b0;
      acc_c = acc;
      q_c   = q;
      if (is_div) begin
         sh    = {acc, q[WIDTH-1]};
         diff  = sh[WIDTH-1:0] - opnd;
         ge    = sh[WIDTH] | (sh[WIDTH-1:0] >= opnd);
         acc_c = ge ? diff : sh[WIDTH-1:0];
         q_c   = {q[WIDTH-2:0], ge};
      end else begin
         sum   = {1'b0, acc} + (q[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
         acc_c = sum[WIDTH:1];
         q_c   = {sum[0], q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One bit per RUN cycle on magnitudes; sign fix-up applied on the FINISH edge.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned N_ITER = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(N_ITER) + 1;
   localparam int unsigned DW    = 2 * WIDTH;

   md_state_e        state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc, q, opnd, a_raw;
   logic [WIDTH-1:0] acc_c, q_c;
   md_ctx_t          ctx;

   logic             last_c, load_c, step_c, fin_c, wr_ok_c;
   logic             busy_d, done_d, dbz_d;
   logic             sgn_c, div_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic [DW-1:0]    prod_c;
   logic [WIDTH-1:0] hi_res_c, lo_res_c;

   assign last_c = (cnt == CNT_W'(N_ITER - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (start)  state_nx = ST_RUN;
         ST_RUN:    if (last_c) state_nx = ST_FINISH;
         ST_FINISH: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Control decode; start has priority over MTHI/MTLO in IDLE
   always_comb begin
      load_c  = 1'b0;
      step_c  = 1'b0;
      fin_c   = 1'b0;
      wr_ok_c = 1'b0;
      unique case (state)
         ST_IDLE: begin
            load_c  = start;
            wr_ok_c = ~start;
         end
         ST_RUN:    step_c = 1'b1;
         ST_FINISH: fin_c  = 1'b1;
         default: ;
      endcase
      busy_d = (state_nx != ST_IDLE);
      done_d = (state == ST_RUN) && last_c;
      dbz_d  = done_d && ctx.is_div && ctx.b_zero;
   end

   // Operand magnitudes for the signed ops
   always_comb begin
      sgn_c   = op_is_signed(op);
      div_c   = op_is_div(op);
      a_mag_c = (sgn_c && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      b_mag_c = (sgn_c && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (ctx.is_div),
      .acc    (acc),
      .q      (q),
      .opnd   (opnd),
      .acc_c  (acc_c),
      .q_c    (q_c)
   );

   // Sign fix-up and divide-by-zero override of the final result
   always_comb begin
      prod_c   = {acc, q};
      hi_res_c = acc;
      lo_res_c = q;
      if (ctx.neg_res) prod_c = ~prod_c + DW'(1);
      if (!ctx.is_div) begin
         {hi_res_c, lo_res_c} = prod_c;
      end else if (ctx.b_zero) begin
         hi_res_c = a_raw;
         lo_res_c = '1;
      end else begin
         lo_res_c = ctx.neg_res ? (~q + WIDTH'(1))   : q;
         hi_res_c = ctx.neg_rem ? (~acc + WIDTH'(1)) : acc;
      end
   end

   // Iteration datapath and counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         acc   <= '0;
         q     <= '0;
         opnd  <= '0;
         a_raw <= '0;
         ctx   <= '0;
      end else if (load_c) begin
         cnt         <= '0;
         acc         <= '0;
         q           <= div_c ? a_mag_c : b_mag_c;
         opnd        <= div_c ? b_mag_c : a_mag_c;
         a_raw       <= a;
         ctx.is_div  <= div_c;
         ctx.neg_res <= sgn_c & (a[WIDTH-1] ^ b[WIDTH-1]);
         ctx.neg_rem <= sgn_c & a[WIDTH-1];
         ctx.b_zero  <= (b == '0);
      end else if (step_c) begin
         cnt <= cnt + CNT_W'(1);
         acc <= acc_c;
         q   <= q_c;
      end
   end

   // Status outputs and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         dbz  <= 1'b0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         dbz  <= dbz_d;
         if (fin_c) begin
            hi <= hi_res_c;
            lo <= lo_res_c;
         end else if (wr_ok_c) begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed mult/div vectors,
// MTHI/MTLO writes, start/write priority, ignored mid-run requests and mid-run reset.
module tb_muldiv_unit;
   import mips_pkg::*;

   logic        clk, rst_n, start, wr_hi, wr_lo;
   logic [1:0]  op;
   logic [31:0] a, b, wr_data;
   logic        busy, done, dbz;
   logic [31:0] hi, lo;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] m_hi, m_lo;

   muldiv_unit #(.WIDTH(32), .N_ITER(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .wr_hi   (wr_hi),
      .wr_lo   (wr_lo),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .dbz     (dbz),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, disturb inputs and pulse start/writes while busy, then check result.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input logic wr_too);
      int n;
      op = o; a = xa; b = xb; start = 1'b1;
      if (wr_too) begin
         wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1111_1111;
      end
      tick();
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      a = $urandom; b = $urandom; op = ~o;
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      chk({tag, ".hold"}, {hi, lo}, {m_hi, m_lo});
      n = 1;
      while (!done && n < 40) begin
         if (n == 5) begin
            start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      chk({tag, ".lat"}, 64'(n), 64'd33);
      chk({tag, ".dbz"}, 64'(dbz), 64'(edbz));
      chk({tag, ".mid"}, {hi, lo}, {m_hi, m_lo});
      tick();
      m_hi = ehi; m_lo = elo;
      chk({tag, ".res"}, {hi, lo}, {ehi, elo});
      chk({tag, ".idle"}, {61'd0, busy, done, dbz}, 64'd0);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b1; start = 1'b0; op = 2'b00;
      a = '0; b = '0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      m_hi = '0; m_lo = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst.ctl", {61'd0, busy, done, dbz}, 64'd0);
      chk("rst.hilo", {hi, lo}, 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("divu",      OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      run_op("divu_zero", OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
      run_op("div_zero",  OP_DIV,   32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("div_rsign", OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
      run_op("mult_mix",  OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
      run_op("divu_one",  OP_DIVU,  32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // MTHI/MTLO in IDLE, both strobes then LO alone
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5_A5A5;
      tick();
      wr_hi = 1'b0; wr_lo = 1'b0;
      m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;
      chk("wr.both", {hi, lo}, {m_hi, m_lo});
      wr_lo = 1'b1; wr_data = 32'h0000_1234;
      tick();
      wr_lo = 1'b0;
      m_lo = 32'h0000_1234;
      chk("wr.lo", {hi, lo}, {m_hi, m_lo});

      // start together with writes: writes dropped, op runs
      run_op("start_wr", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);

      // Reset at RUN cycle 10 aborts with no result and no done pulse
      op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("abort.busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      chk("abort.ctl", {61'd0, busy, done, dbz}, 64'd0);
      chk("abort.hilo", {hi, lo}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort.nodone", {62'd0, busy, done}, 64'd0);
      end
      rst_n = 1'b1;

      run_op("post_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is required.
REQ-002 Parameter N_ITER, default 32, iteration count per operation; SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  operation: MULT=00, MULTU=01, DIV=10, DIVU=11.
REQ-007 a  input  32  rs operand (multiplicand or dividend).
REQ-008 b  input  32  rt operand (multiplier or divisor).
REQ-009 wr_hi, wr_lo  input  1 each  MTHI/MTLO write strobes.
REQ-010 wr_data  input  32  MTHI/MTLO data.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 dbz  output  1  divide-by-zero flag; valid only while done=1.
REQ-014 hi, lo  output  32 each  architectural HI/LO registers (MFHI/MFLO source).

Function
REQ-015 FSM states IDLE, RUN, FINISH; IDLE->RUN on start=1; RUN->FINISH after N_ITER RUN cycles; FINISH->IDLE unconditionally.
REQ-016 On start acceptance, a, b and op SHALL be latched; later input changes have no effect on the result.
REQ-017 busy=1 in RUN and FINISH; busy=0 in IDLE.
REQ-018 Latency: if start is sampled at edge E, done=1 during the cycle after edge E+32, and hi/lo hold the result from edge E+33 onward.
REQ-019 MULT/MULTU: {hi,lo} = 64-bit product; MULTU is unsigned; MULT operates on magnitudes and negates the 64-bit product when the operand signs differ.
REQ-020 DIV/DIVU: lo = quotient, hi = remainder via restoring shift-subtract, one bit per RUN cycle; DIV truncates toward zero, and the remainder takes the sign of the dividend.
REQ-021 Divisor 0 (DIV or DIVU): lo=32'hFFFFFFFF, hi=a, dbz=1 in the done cycle; latency unchanged.
REQ-022 DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0, dbz=0.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 wr_hi/wr_lo in IDLE update hi/lo at the next edge; both may be asserted in the same cycle.
REQ-025 wr_hi/wr_lo while busy=1 SHALL be ignored.
REQ-026 start and wr_hi/wr_lo asserted together in IDLE: start wins and the writes are dropped.
REQ-027 hi/lo SHALL change only on the FINISH edge, an accepted write, or reset.
REQ-028 dbz=0 whenever done=0.
REQ-029 Back-to-back: start may be accepted in the cycle immediately after done.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, and clear the iteration counter and working registers.
REQ-031 Reset during RUN or FINISH aborts the operation; no partial result reaches hi/lo.
REQ-032 The first start SHALL be accepted on the first edge at which rst_n is high.

Structure
REQ-033 The op encodings (MULT/MULTU/DIV/DIVU) and the FSM state encoding SHALL live in the shared mips_pkg.
REQ-034 One sub-module, muldiv_step, SHALL hold the combinational single-iteration add-shift / subtract-shift datapath; muldiv_unit holds the FSM, counter, sign fix-up and HI/LO.
REQ-035 The iteration counter SHALL be $clog2(N_ITER)+1 bits wide.

Verification
REQ-036 MULTU a=32'hFFFFFFFF, b=32'h2 -> hi=1, lo=32'hFFFFFFFE, done 33 cycles after start.
REQ-037 MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-038 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=100, b=7 -> lo=14, hi=2.
REQ-039 DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, dbz=1 for exactly one cycle.
REQ-040 start plus wr_hi pulsed mid-RUN, then rst_n low at RUN cycle 10 -> the first result is unaffected by the mid-RUN pulses, then busy=0 and hi=lo=0 immediately, with no done pulse.
REQ-041 wr_hi=wr_lo=1, wr_data=32'hA5A5A5A5 in IDLE -> hi=lo=32'hA5A5A5A5 next cycle; the same with start=1 -> writes dropped and the operation runs.
